// File: rtl/pb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : pb_uart_rx
// Purpose  : UART receiver (8N1, optional 8E1) with a show-ahead receive
//            FIFO, sticky error flags and a selectable level interrupt.
// Ports    : clk_i, rst_i (async, active-high)
//            baud_x16_i   - one-cycle tick at 16x the baud rate
//            rx_pad_i     - asynchronous serial input, idle high
//            rx_read_i    - FIFO pop strobe
//            int_sel_i    - interrupt source: 00 off, 01 not-empty,
//                           10 half-full, 11 full
//            clear_err_i  - clears sticky error flags
//            rx_data_o    - FIFO head byte (show-ahead, 0x00 when empty)
//            fifo_count_o, fifo_empty_o, fifo_half_o, fifo_full_o
//            rx_int_o     - registered level interrupt
//            frame_err_o, overrun_o - sticky errors
//            parity_err_o - sticky parity error (PB_UART_RX_PARITY_EN only)
// Config   : define PB_UART_RX_PARITY_EN to add an even-parity bit after
//            the data bits; undefined gives a plain 8N1 receiver.
// Revision : 1.0 - initial release
// ============================================================================
module pb_uart_rx #(
  parameter int FIFO_AW = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             baud_x16_i,
  input  logic             rx_pad_i,
  input  logic             rx_read_i,
  input  logic [1:0]       int_sel_i,
  input  logic             clear_err_i,
  output logic [7:0]       rx_data_o,
  output logic [FIFO_AW:0] fifo_count_o,
  output logic             fifo_empty_o,
  output logic             fifo_half_o,
  output logic             fifo_full_o,
  output logic             rx_int_o,
  output logic             frame_err_o,
  output logic             overrun_o
`ifdef PB_UART_RX_PARITY_EN
  ,output logic            parity_err_o
`endif
);

  localparam logic [FIFO_AW:0]   c_depth   = (FIFO_AW+1)'(2**FIFO_AW);
  localparam logic [FIFO_AW:0]   c_half    = (FIFO_AW+1)'(2**(FIFO_AW-1));
  localparam logic [FIFO_AW:0]   c_cnt_one = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] c_ptr_one = FIFO_AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef PB_UART_RX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d, sync2_q, sync2_d, line_prev_q, line_prev_d;
  logic [3:0]         tick_cnt_q, tick_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic               rx_int_q, rx_int_d;
  logic [7:0]         mem_q [2**FIFO_AW];

  logic               w_push_req, w_frame_set, w_overrun_set;
  logic               w_do_push, w_do_pop, w_empty, w_full, w_half, w_int_cond;
`ifdef PB_UART_RX_PARITY_EN
  logic               parity_bad_q, parity_bad_d, parity_err_q, parity_err_d;
  logic               w_parity_set;
`endif

  // Receiver FSM: all sampling decisions use the synchronized line sync2_q.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    w_push_req   = 1'b0;
    w_frame_set  = 1'b0;
    sync1_d      = rx_pad_i;
    sync2_d      = sync1_q;
    line_prev_d  = sync2_q;
`ifdef PB_UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    w_parity_set = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Ticks are ignored here; only a falling edge starts a frame.
        if (line_prev_q && !sync2_q) begin
          state_d    = ST_START;
          tick_cnt_d = 4'd0;
        end
      end
      ST_START: begin
        if (baud_x16_i) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd7) begin
            if (!sync2_q) begin
              state_d    = ST_DATA;
              tick_cnt_d = 4'd0;
              bit_cnt_d  = 3'd0;
            end else begin
              state_d    = ST_IDLE;   // false start
            end
          end
        end
      end
      ST_DATA: begin
        // Counter wraps 15->0, so every 16th tick lands on a bit midpoint.
        if (baud_x16_i) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d   = {sync2_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef PB_UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
      end
`ifdef PB_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (baud_x16_i) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            parity_bad_d = ^{shift_q, sync2_q};
            state_d      = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        // Back to IDLE right at the stop midpoint so a start bit that
        // follows without idle time is still caught.
        if (baud_x16_i) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            state_d = ST_IDLE;
            if (!sync2_q) begin
              w_frame_set = 1'b1;
`ifdef PB_UART_RX_PARITY_EN
            end else if (parity_bad_q) begin
              w_parity_set = 1'b1;
`endif
            end else begin
              w_push_req = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping and status.
  always_comb begin
    w_empty       = (count_q == '0);
    w_full        = (count_q == c_depth);
    w_half        = (count_q >= c_half);
    w_do_pop      = rx_read_i && !w_empty;
    // When full, a push only fits if a pop frees a slot in the same cycle.
    w_do_push     = w_push_req && (!w_full || rx_read_i);
    w_overrun_set = w_push_req && w_full && !rx_read_i;
    wr_ptr_d      = w_do_push ? wr_ptr_q + c_ptr_one : wr_ptr_q;
    rd_ptr_d      = w_do_pop  ? rd_ptr_q + c_ptr_one : rd_ptr_q;
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
    // A new error event takes priority over a coincident clear.
    frame_err_d   = w_frame_set   ? 1'b1 : (clear_err_i ? 1'b0 : frame_err_q);
    overrun_d     = w_overrun_set ? 1'b1 : (clear_err_i ? 1'b0 : overrun_q);
`ifdef PB_UART_RX_PARITY_EN
    parity_err_d  = w_parity_set  ? 1'b1 : (clear_err_i ? 1'b0 : parity_err_q);
`endif
    case (int_sel_i)
      2'b01:   w_int_cond = !w_empty;
      2'b10:   w_int_cond = w_half;
      2'b11:   w_int_cond = w_full;
      default: w_int_cond = 1'b0;
    endcase
    rx_int_d      = w_int_cond;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      line_prev_q  <= 1'b1;
      tick_cnt_q   <= 4'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      rx_int_q     <= 1'b0;
`ifdef PB_UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      line_prev_q  <= line_prev_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      rx_int_q     <= rx_int_d;
`ifdef PB_UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rx_data_o    = w_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign fifo_count_o = count_q;
  assign fifo_empty_o = w_empty;
  assign fifo_half_o  = w_half;
  assign fifo_full_o  = w_full;
  assign rx_int_o     = rx_int_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
`ifdef PB_UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: doc/pb_uart_rx.md
PB_UART_RX -- requirements
Module: pb_uart_rx

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, receive FIFO address width; depth is 2^FIFO_AW entries.
REQ-002 SHALL have port clk_i  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port baud_x16_i  input  1  one-cycle tick at 16x baud rate, from the baud generator.
REQ-005 SHALL have port rx_pad_i  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_read_i  input  1  one-cycle FIFO pop strobe from the register file.
REQ-007 SHALL have port int_sel_i  input  2  interrupt source: 00 off, 01 not-empty, 10 half-full, 11 full.
REQ-008 SHALL have port clear_err_i  input  1  clears the sticky error flags.
REQ-009 SHALL have port rx_data_o  output  8  FIFO head byte, show-ahead.
REQ-010 SHALL have port fifo_count_o  output  FIFO_AW+1  FIFO occupancy.
REQ-011 SHALL have ports fifo_empty_o, fifo_half_o and fifo_full_o, each output 1: empty (count=0), half (count>=depth/2) and full (count=depth).
REQ-012 SHALL have port rx_int_o  output  1  level interrupt to pb_interrupts.
REQ-013 SHALL have ports frame_err_o and overrun_o, each output 1: sticky framing error and sticky overrun error.

Function
REQ-014 SHALL pass rx_pad_i through a 2-flop synchronizer; the synchronizer flops SHALL reset to 1.
REQ-015 SHALL implement FSM states IDLE, START, DATA and STOP, plus PARITY when that feature is compiled in.
REQ-016 IDLE SHALL move to START on a synchronized 1->0 edge and SHALL clear the 4-bit tick counter.
REQ-017 START SHALL sample the line on the 8th baud_x16_i tick: a 0 moves to DATA; a 1 is a false start and returns to IDLE with nothing logged.
REQ-018 DATA SHALL sample every 16 ticks after the start-bit midpoint and shift in 8 bits, LSB first.
REQ-019 STOP SHALL sample the line at the stop-bit midpoint and then return to IDLE in the same cycle, so back-to-back frames with no idle gap are received.
REQ-020 A stop bit of 0 SHALL set frame_err_o and discard the byte.
REQ-021 A valid stop bit with the FIFO not full SHALL push the byte; rx_data_o and the count SHALL update on the cycle after the stop sample.
REQ-022 A push with the FIFO full and no simultaneous pop SHALL drop the byte, set overrun_o and leave the FIFO contents unchanged.
REQ-023 A push and a pop in the same cycle with the FIFO full SHALL both succeed with the count unchanged.
REQ-024 A pop with the FIFO empty SHALL be ignored, and the count SHALL NOT underflow.
REQ-025 A push and a pop in the same cycle with the FIFO empty SHALL ignore the pop and leave the count at 1.
REQ-026 The read and write pointers SHALL wrap modulo 2^FIFO_AW, and the count SHALL never exceed the depth.
REQ-027 clear_err_i SHALL clear both error flags; if it coincides with a new error event, the error SHALL win and the flag SHALL stay set.
REQ-028 rx_int_o SHALL be a registered, level-sensitive output selected by int_sel_i and SHALL drop the cycle after the selected condition goes false.
REQ-029 Ticks arriving while in IDLE SHALL have no effect on the receiver.

Reset
REQ-030 rst_i SHALL asynchronously force the FSM to IDLE, the tick counter, bit counter and pointers to 0, and the synchronizer to 1.
REQ-031 Reset values SHALL be: rx_data_o 0x00, fifo_count_o 0, fifo_empty_o 1, fifo_half_o 0, fifo_full_o 0, rx_int_o 0, frame_err_o 0, overrun_o 0.
REQ-032 A reset asserted mid-frame SHALL abandon the frame, and the partial byte SHALL never be pushed.

Configuration
REQ-033 Macro PB_UART_RX_PARITY_EN defined SHALL add a PARITY state after DATA that samples an even-parity bit.
REQ-034 With PB_UART_RX_PARITY_EN defined, a parity mismatch SHALL discard the byte and set the sticky output parity_err_o, which is cleared by clear_err_i.
REQ-035 With PB_UART_RX_PARITY_EN undefined, the frame SHALL be 8N1 and port parity_err_o SHALL NOT exist.

Verification
REQ-036 Receive 0xA5 at 16 ticks/bit -> fifo_count_o=1, rx_data_o=0xA5, fifo_empty_o=0, rx_int_o=1 with int_sel_i=01.
REQ-037 Apply a 3-tick low glitch on an idle line -> no push, FSM back in IDLE, no error flags set.
REQ-038 Send 17 bytes 0x00..0x10 with FIFO_AW=4 and no reads -> fifo_full_o=1, overrun_o=1, 16 pops return 0x00..0x0F.
REQ-039 Send frame 0x3C with stop bit 0 -> frame_err_o=1, count unchanged; clear_err_i pulse -> frame_err_o=0.
REQ-040 With FIFO full, pop coincident with a push of 0x77 -> count stays 16, 0x77 is the last entry read out.
REQ-041 Assert rst_i after 4 data bits of 0xFF -> all outputs at reset values; a following 0x12 is received correctly.
